shim_adc_timing_calc_gen: RTL

- Generalised successor of the ADS816x n_cs timing calculator.
- Computes the minimum n_cs high time in SPI clocks from the SPI clock frequency and the conversion/cycle times of a model selected at run time (ADS8166/7/8, or a custom programmed time pair).
- Also reports the conversion wait cycles and a saturation flag; the command length and output width are configurable.
- Sits between the SPI clock configuration registers and the ADC SPI sequencer. Compute is a multi-cycle shift-add, no DSP.

---
 rtl/shim_adc_timing_calc_gen_if.sv | 28 ++
 rtl/shim_adc_timing_calc_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shim_adc_timing_calc_gen_if.sv
// Configuration/result bundle between the SPI clock registers, the
// n_cs timing calculator and the ADC SPI sequencer.
interface shim_adc_timing_calc_gen_if #(
  parameter int FREQ_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic [FREQ_WIDTH-1:0] spi_clk_freq_hz;
  logic [1:0]            model_sel;
  logic [15:0]           t_conv_nis;
  logic [15:0]           t_cycle_nis;
  logic [5:0]            cmd_bits;
  logic                  calc;
  logic [OUT_WIDTH-1:0]  n_cs_high_time;
  logic [OUT_WIDTH-1:0]  conv_wait_cycles;
  logic                  saturated;
  logic                  done;
  logic                  lock_viol;

  modport master (
    output spi_clk_freq_hz, model_sel, t_conv_nis, t_cycle_nis, cmd_bits, calc,
    input  n_cs_high_time, conv_wait_cycles, saturated, done, lock_viol
  );

  modport slave (
    input  spi_clk_freq_hz, model_sel, t_conv_nis, t_cycle_nis, cmd_bits, calc,
    output n_cs_high_time, conv_wait_cycles, saturated, done, lock_viol
  );
endinterface

// File: rtl/shim_adc_timing_calc_gen.sv
// ADS816x n_cs high-time calculator: shift-add multiply of the SPI clock by the
// model conversion/cycle times (NiS, 2^30 per second), scaled back to SPI clocks.
module shim_adc_timing_calc_gen #(
  parameter int FREQ_WIDTH      = 32,
  parameter int OUT_WIDTH       = 8,
  parameter int MIN_CONV_CYCLES = 3,
  parameter int ROUND_UP        = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  shim_adc_timing_calc_gen_if.slave  bus
);
  localparam int ACC_W = FREQ_WIDTH + 16;
  localparam logic [ACC_W-1:0] ZERO     = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] ONE      = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] SAT_MAX  = {{(ACC_W-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
  localparam logic [ACC_W-1:0] MIN_CONV = ACC_W'(MIN_CONV_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_SCALE = 3'd2,
    ST_MAX   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [FREQ_WIDTH-1:0] f_r;
  logic [1:0]            sel_r;
  logic [5:0]            cmd_r;
  logic [15:0]           tc_r, ty_r;
  logic [3:0]            idx_r;
  logic [ACC_W-1:0]      acc_c_r, acc_y_r, conv_r, cyc_r;
  logic [OUT_WIDTH-1:0]  n_cs_r, conv_wait_r;
  logic                  sat_r, done_r, lock_viol_r;

  logic                  lock_chg_s, busy_s, advance_s;
  logic [ACC_W-1:0]      f_sh_s, cmd_ext_s, cc_s, cy_s, conv_s, cyc_s, r_s;

  function automatic logic [15:0] tbl_conv(input logic [1:0] sel, input logic [15:0] custom);
    case (sel)
      2'd0:    tbl_conv = 16'd2685;
      2'd1:    tbl_conv = 16'd1289;
      2'd2:    tbl_conv = 16'd709;
      default: tbl_conv = custom;
    endcase
  endfunction

  function automatic logic [15:0] tbl_cycle(input logic [1:0] sel, input logic [15:0] custom);
    case (sel)
      2'd0:    tbl_cycle = 16'd4295;
      2'd1:    tbl_cycle = 16'd2148;
      2'd2:    tbl_cycle = 16'd1074;
      default: tbl_cycle = custom;
    endcase
  endfunction

  // Lock comparison plus the scale/max arithmetic feeding the datapath registers
  always_comb begin
    // tc_r/ty_r equal the custom inputs whenever the latched model is custom
    lock_chg_s = (bus.spi_clk_freq_hz != f_r) || (bus.model_sel != sel_r) ||
                 (bus.cmd_bits != cmd_r) ||
                 ((sel_r == 2'd3) && ((bus.t_conv_nis != tc_r) || (bus.t_cycle_nis != ty_r)));
    f_sh_s    = ACC_W'(f_r) << idx_r;
    cmd_ext_s = ACC_W'(cmd_r);
    cc_s      = (acc_c_r >> 30) + (((ROUND_UP != 0) && (acc_c_r[29:0] != 30'd0)) ? ONE : ZERO);
    cy_s      = (acc_y_r >> 30) + (((ROUND_UP != 0) && (acc_y_r[29:0] != 30'd0)) ? ONE : ZERO);
    conv_s    = (cc_s > MIN_CONV) ? cc_s : MIN_CONV;
    cyc_s     = (cy_s > cmd_ext_s) ? (cy_s - cmd_ext_s) : ZERO;
    r_s       = (conv_r > cyc_r) ? conv_r : cyc_r;
  end

  // Next-state selection with lock violation taking priority over calc drop
  always_comb begin
    state_nxt_s = state_r;
    busy_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.calc) state_nxt_s = ST_MUL;
        else          state_nxt_s = ST_IDLE;
      end
      ST_MUL, ST_SCALE, ST_MAX, ST_DONE: begin
        busy_s = 1'b1;
        if (lock_chg_s)               state_nxt_s = ST_ERR;
        else if (!bus.calc)           state_nxt_s = ST_IDLE;
        else if (state_r == ST_MUL)   state_nxt_s = (idx_r == 4'd15) ? ST_SCALE : ST_MUL;
        else if (state_r == ST_SCALE) state_nxt_s = ST_MAX;
        else                          state_nxt_s = ST_DONE;
      end
      ST_ERR: begin
        if (!bus.calc) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_ERR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    advance_s = busy_s && !lock_chg_s && bus.calc;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Latches, accumulators and registered results
  always_ff @(posedge clk) begin
    if (!resetn) begin
      f_r         <= {FREQ_WIDTH{1'b0}};
      sel_r       <= 2'd0;
      cmd_r       <= 6'd0;
      tc_r        <= 16'd0;
      ty_r        <= 16'd0;
      idx_r       <= 4'd0;
      acc_c_r     <= ZERO;
      acc_y_r     <= ZERO;
      conv_r      <= ZERO;
      cyc_r       <= ZERO;
      n_cs_r      <= {OUT_WIDTH{1'b0}};
      conv_wait_r <= {OUT_WIDTH{1'b0}};
      sat_r       <= 1'b0;
      done_r      <= 1'b0;
      lock_viol_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          lock_viol_r <= 1'b0;
          done_r      <= 1'b0;
          if (bus.calc) begin
            f_r     <= bus.spi_clk_freq_hz;
            sel_r   <= bus.model_sel;
            cmd_r   <= bus.cmd_bits;
            tc_r    <= tbl_conv(bus.model_sel, bus.t_conv_nis);
            ty_r    <= tbl_cycle(bus.model_sel, bus.t_cycle_nis);
            acc_c_r <= ZERO;
            acc_y_r <= ZERO;
            idx_r   <= 4'd0;
          end
        end
        ST_MUL: begin
          if (advance_s) begin
            if (tc_r[idx_r]) acc_c_r <= acc_c_r + f_sh_s;
            if (ty_r[idx_r]) acc_y_r <= acc_y_r + f_sh_s;
            idx_r <= idx_r + 4'd1;
          end
        end
        ST_SCALE: begin
          if (advance_s) begin
            conv_r <= conv_s;
            cyc_r  <= cyc_s;
          end
        end
        ST_MAX: begin
          if (advance_s) begin
            n_cs_r      <= (r_s > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] : r_s[OUT_WIDTH-1:0];
            conv_wait_r <= (conv_r > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] : conv_r[OUT_WIDTH-1:0];
            sat_r       <= (r_s > SAT_MAX) || (conv_r > SAT_MAX);
            done_r      <= 1'b1;
          end
        end
        ST_ERR: begin
          lock_viol_r <= 1'b1;
          done_r      <= 1'b0;
        end
        default: begin
        end
      endcase
      // Aborts override whatever the state branch scheduled for done/lock_viol
      if (busy_s && lock_chg_s) begin
        lock_viol_r <= 1'b1;
        done_r      <= 1'b0;
      end else if (busy_s && !bus.calc) begin
        done_r      <= 1'b0;
      end
    end
  end

  assign bus.n_cs_high_time   = n_cs_r;
  assign bus.conv_wait_cycles = conv_wait_r;
  assign bus.saturated        = sat_r;
  assign bus.done             = done_r;
  assign bus.lock_viol        = lock_viol_r;
endmodule
